// File: rtl/instruction_fetcher.sv
// Instruction fetcher: PC register, fetch handshake with the instruction cache and a
// circular fetch queue. Optional JAL target prediction under FETCH_JAL_PREDICT_EN.
module instruction_fetcher #(
  parameter int FQ_DEPTH     = 8,
  parameter int FQ_DEPTH_LOG = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] icache_pc,
  input  logic [31:0] icache_inst,
  input  logic        icache_valid,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  input  logic        deq_en,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pred_pc_out
);

  localparam logic [FQ_DEPTH_LOG:0]   full_count = FQ_DEPTH[FQ_DEPTH_LOG:0];
  localparam logic [FQ_DEPTH_LOG:0]   cnt_one    = 1;
  localparam logic [FQ_DEPTH_LOG-1:0] ptr_one    = 1;

  logic [31:0]             pc;
  logic                    settled;
  logic [FQ_DEPTH_LOG-1:0] head;
  logic [FQ_DEPTH_LOG-1:0] tail;
  logic [FQ_DEPTH_LOG:0]   count;

  logic [31:0] fq_inst [FQ_DEPTH];
  logic [31:0] fq_pc   [FQ_DEPTH];
  logic [31:0] fq_pred [FQ_DEPTH];

  logic [31:0] next_pc;
  logic        accept;
  logic        pop;

`ifdef FETCH_JAL_PREDICT_EN
  logic [31:0] jal_imm;
  assign jal_imm = {{11{icache_inst[31]}}, icache_inst[31], icache_inst[19:12],
                    icache_inst[20], icache_inst[30:21], 1'b0};
  assign next_pc = (icache_inst[6:0] == 7'b1101111) ? pc + jal_imm : pc + 32'd4;
`else
  assign next_pc = pc + 32'd4;
`endif

  // Cache word is trusted only once the PC has been stable for a full cycle (settled),
  // so a word returned for the previous address is never enqueued.
  assign accept = rdy_in && settled && icache_valid && (count != full_count) && !flush_in;

  // Consumer handshake: inst_valid_out is the valid, deq_en the ready; an entry
  // transfers on a rising edge where both are high (and rdy_in high, no flush).
  assign pop = rdy_in && deq_en && (count != '0) && !flush_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc      <= '0;
      settled <= 1'b0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        pc      <= flush_pc;
        settled <= 1'b0;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
      end else begin
        if (accept) begin
          tail    <= tail + ptr_one;
          pc      <= next_pc;
          settled <= 1'b0;
        end else begin
          settled <= 1'b1;
        end
        if (pop) head <= head + ptr_one;
        if (accept && !pop)      count <= count + cnt_one;
        else if (!accept && pop) count <= count - cnt_one;
      end
    end
  end

  // Queue storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      fq_inst[tail] <= icache_inst;
      fq_pc[tail]   <= pc;
      fq_pred[tail] <= next_pc;
    end
  end

  assign icache_pc      = pc;
  assign inst_valid_out = (count != '0);
  assign inst_out       = inst_valid_out ? fq_inst[head] : 32'h0;
  assign pc_out         = inst_valid_out ? fq_pc[head]   : 32'h0;
  assign pred_pc_out    = inst_valid_out ? fq_pred[head] : 32'h0;

endmodule
